// File: rtl/grad_mag_dir.sv
// Gradient magnitude / direction stage: streams the gradient memory once per start,
// writes a saturated L1 magnitude plus a 2-bit direction bin per pixel, and tracks
// the edge-pixel count and peak magnitude for the pass.
module grad_mag_dir #(
    parameter int unsigned WIDTH  = 256,
    parameter int unsigned HEIGHT = 256,
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned THRESH = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              grad_rd,
    output logic [ADDR_W-1:0] grad_addr,
    input  logic [19:0]       grad_di,
    output logic              mag_wr,
    output logic [ADDR_W-1:0] mag_addr,
    output logic [9:0]        mag_do,
    output logic [ADDR_W:0]   edge_cnt,
    output logic [7:0]        max_mag,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ONE_A = 1;
    localparam logic [ADDR_W:0]   ONE_E = 1;

    typedef enum logic [1:0] {IDLE, READ, DRAIN, DONE} state_t;

    state_t            state_q, state_d;
    logic              start_ok;
    logic              rd_valid;
    logic [ADDR_W-1:0] rd_addr;
    logic [9:0]        gx, gy;
    logic [10:0]       ax, ay;
    logic [11:0]       sum;
    logic [7:0]        mag;
    logic [1:0]        dir;

    // Control outputs are pure state decodes, so reset forces them all low.
    assign grad_rd = (state_q == READ);
    assign busy    = (state_q == READ) || (state_q == DRAIN);
    assign done    = (state_q == DONE);

    // Next-state logic: start only honoured when idle or finished.
    always_comb begin
        state_d  = state_q;
        start_ok = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d  = READ;
                    start_ok = 1'b1;
                end
            end
            READ:    if (grad_addr == LAST) state_d = DRAIN;
            DRAIN:   if (!rd_valid) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Read address counter: restarts on accepted start, stops at the last pixel.
    always_ff @(posedge clk) begin
        if (!reset)                                 grad_addr <= '0;
        else if (start_ok)                          grad_addr <= '0;
        else if (state_q == READ && grad_addr != LAST) grad_addr <= grad_addr + ONE_A;
    end

    // Magnitude and direction of the word returned by the memory this cycle.
    always_comb begin
        gx  = grad_di[19:10];
        gy  = grad_di[9:0];
        // {1'b1, g} is the 11-bit sign extension of a negative g, so -512 maps to 512.
        ax  = gx[9] ? (11'd0 - {1'b1, gx}) : {1'b0, gx};
        ay  = gy[9] ? (11'd0 - {1'b1, gy}) : {1'b0, gy};
        sum = {1'b0, ax} + {1'b0, ay};
        mag = (sum > 12'd255) ? 8'hFF : sum[7:0];
        if ({1'b0, ax} >= {ay, 1'b0})      dir = 2'd0;
        else if ({1'b0, ay} >= {ax, 1'b0}) dir = 2'd1;
        else if (gx[9] == gy[9])           dir = 2'd2;
        else                               dir = 2'd3;
    end

    // Two-stage pipeline: read-data valid tag, then registered write port.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rd_valid <= 1'b0;
            rd_addr  <= '0;
            mag_wr   <= 1'b0;
            mag_addr <= '0;
            mag_do   <= '0;
        end else begin
            rd_valid <= grad_rd;
            rd_addr  <= grad_addr;
            mag_wr   <= rd_valid;
            if (rd_valid) begin
                mag_addr <= rd_addr;
                mag_do   <= {dir, mag};
            end
        end
    end

    // Pass statistics, updated on each write and cleared when a new pass is accepted.
    always_ff @(posedge clk) begin
        if (!reset || start_ok) begin
            edge_cnt <= '0;
            max_mag  <= '0;
        end else if (mag_wr) begin
            if (32'(mag_do[7:0]) >= THRESH) edge_cnt <= edge_cnt + ONE_E;
            if (mag_do[7:0] > max_mag)      max_mag  <= mag_do[7:0];
        end
    end

endmodule

// File: tb/tb_grad_mag_dir.sv
// Scoreboard bench for grad_mag_dir on a reduced 8x4 image.
module tb_grad_mag_dir;

    localparam int unsigned W  = 8;
    localparam int unsigned H  = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned N  = W * H;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic          grad_rd;
    logic [AW-1:0] grad_addr;
    logic [19:0]   grad_di = '0;
    logic          mag_wr;
    logic [AW-1:0] mag_addr;
    logic [9:0]    mag_do;
    logic [AW:0]   edge_cnt;
    logic [7:0]    max_mag;
    logic          busy;
    logic          done;

    grad_mag_dir #(.WIDTH(W), .HEIGHT(H), .ADDR_W(AW), .THRESH(32)) dut (
        .clk(clk), .reset(reset), .start(start),
        .grad_rd(grad_rd), .grad_addr(grad_addr), .grad_di(grad_di),
        .mag_wr(mag_wr), .mag_addr(mag_addr), .mag_do(mag_do),
        .edge_cnt(edge_cnt), .max_mag(max_mag), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    logic [19:0]   mem     [N];
    logic [9:0]    exp_mem [N];
    logic [AW-1:0] exp_addr_q [$];
    logic [9:0]    exp_data_q [$];
    int            errors = 0;
    int            checks = 0;

    // Synchronous-read gradient memory model.
    always @(posedge clk) if (grad_rd) grad_di <= mem[grad_addr];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [19:0] mk(input int gx, input int gy);
        logic [9:0] a, b;
        a = 10'(gx);
        b = 10'(gy);
        return {a, b};
    endfunction

    task automatic fill(input int gx, input int gy, input logic [9:0] e);
        for (int i = 0; i < int'(N); i++) begin
            mem[i]     = mk(gx, gy);
            exp_mem[i] = e;
        end
    endtask

    task automatic put(input int a, input int gx, input int gy, input logic [9:0] e);
        mem[a]     = mk(gx, gy);
        exp_mem[a] = e;
    endtask

    task automatic push_all();
        for (int i = 0; i < int'(N); i++) begin
            exp_addr_q.push_back(AW'(i));
            exp_data_q.push_back(exp_mem[i]);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_grad_rd"},   int'(grad_rd),   0);
        chk({tag, "_grad_addr"}, int'(grad_addr), 0);
        chk({tag, "_mag_wr"},    int'(mag_wr),    0);
        chk({tag, "_mag_addr"},  int'(mag_addr),  0);
        chk({tag, "_mag_do"},    int'(mag_do),    0);
        chk({tag, "_edge_cnt"},  int'(edge_cnt),  0);
        chk({tag, "_max_mag"},   int'(max_mag),   0);
        chk({tag, "_busy"},      int'(busy),      0);
        chk({tag, "_done"},      int'(done),      0);
    endtask

    // One full pass; optionally pulses start while busy (must be ignored).
    task automatic run_pass(input string tag, input bit pulses, input int exp_edge, input int exp_max);
        int cyc;
        push_all();
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        chk({tag, "_accept_busy"},  int'(busy),      1);
        chk({tag, "_accept_rd"},    int'(grad_rd),   1);
        chk({tag, "_accept_addr"},  int'(grad_addr), 0);
        chk({tag, "_accept_done"},  int'(done),      0);
        chk({tag, "_accept_edge"},  int'(edge_cnt),  0);
        chk({tag, "_accept_max"},   int'(max_mag),   0);
        cyc = 0;
        while (!done && cyc < 4 * int'(N)) begin
            @(posedge clk) #1;
            cyc++;
            start = pulses && (cyc == 5 || cyc == 20);
        end
        start = 1'b0;
        chk({tag, "_done_latency"}, cyc, int'(N) + 2);
        chk({tag, "_busy_off"},     int'(busy), 0);
        chk({tag, "_edge_cnt"},     int'(edge_cnt), exp_edge);
        chk({tag, "_max_mag"},      int'(max_mag), exp_max);
        chk({tag, "_sb_empty"},     exp_addr_q.size(), 0);
        repeat (2) @(posedge clk) #1;
        chk({tag, "_done_held"},    int'(done), 1);
        chk({tag, "_no_wr_after"},  int'(mag_wr), 0);
    endtask

    // Monitor: pops the scoreboard on every write and checks 2-cycle read->write latency.
    logic          h1_rd = 1'b0, h2_rd = 1'b0;
    logic [AW-1:0] h1_addr = '0, h2_addr = '0;
    always @(negedge clk) begin
        if (!reset) begin
            h1_rd = 1'b0;
            h2_rd = 1'b0;
        end else begin
            if (mag_wr) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: mag_addr=%0d mag_do=0x%0h with empty scoreboard", mag_addr, mag_do);
                end else begin
                    logic [AW-1:0] ea;
                    logic [9:0]    ed;
                    ea = exp_addr_q.pop_front();
                    ed = exp_data_q.pop_front();
                    chk("mag_addr", int'(mag_addr), int'(ea));
                    chk("mag_do", int'(mag_do), int'(ed));
                    chk("rd_to_wr_latency", int'({h2_rd, h2_addr}), int'({1'b1, ea}));
                end
            end
            h2_rd   = h1_rd;
            h2_addr = h1_addr;
            h1_rd   = grad_rd;
            h1_addr = grad_addr;
        end
    end

    initial begin
        int cyc;
        fill(0, 0, 10'h000);
        repeat (3) @(posedge clk) #1;
        chk_zero("reset");
        reset = 1'b1;

        // All-zero gradients.
        run_pass("zero", 1'b0, 0, 0);

        // Uniform {+100,-20}: mag 120, horizontal.
        fill(100, -20, 10'h078);
        run_pass("uniform", 1'b0, int'(N), 120);

        // Spot words: saturation, diagonal, anti-diagonal, vertical, -512.
        fill(0, 0, 10'h000);
        put(3, -255, -255, 10'h2FF);
        put(4, 30, -40, 10'h346);
        put(5, 5, 60, 10'h141);
        put(6, -512, 0, 10'h0FF);
        run_pass("spot", 1'b0, 4, 255);

        // Threshold boundary: 31 is not an edge, 32 is.
        fill(0, 0, 10'h000);
        put(7, 31, 0, 10'h01F);
        put(9, 32, 0, 10'h020);
        run_pass("thresh", 1'b0, 1, 32);

        // Reset mid-pass after pixel 10 is written.
        fill(100, -20, 10'h078);
        push_all();
        @(negedge clk) start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!(mag_wr && mag_addr == AW'(10)) && cyc < 4 * int'(N));
        chk("midpass_reached", int'(mag_wr && mag_addr == AW'(10)), 1);
        @(posedge clk) #1 reset = 1'b0;
        @(posedge clk) #1;
        chk_zero("midreset");
        @(posedge clk) #1;
        chk("midreset_hold_wr", int'(mag_wr), 0);
        reset = 1'b1;
        exp_addr_q.delete();
        exp_data_q.delete();
        repeat (3) begin
            @(posedge clk) #1;
            chk("post_reset_wr", int'(mag_wr), 0);
            chk("post_reset_rd", int'(grad_rd), 0);
        end
        fill(0, 0, 10'h000);
        put(3, -255, -255, 10'h2FF);
        put(4, 30, -40, 10'h346);
        put(5, 5, 60, 10'h141);
        put(6, -512, 0, 10'h0FF);
        run_pass("clean", 1'b0, 4, 255);

        // Start pulses while busy are ignored; start from DONE re-runs identically.
        run_pass("busy_start", 1'b1, 4, 255);
        run_pass("rerun", 1'b0, 4, 255);

        // Start and reset together: reset wins.
        @(negedge clk) begin
            start = 1'b1;
            reset = 1'b0;
        end
        @(posedge clk) #1;
        chk("rst_start_busy", int'(busy), 0);
        chk("rst_start_done", int'(done), 0);
        chk("rst_start_rd", int'(grad_rd), 0);
        start = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clk) #1;
        chk("rst_start_idle", int'(busy), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
